// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 keyboard receiver bus: raw connector lines in, decoded key code and event strobes out.
// master = receiver side, slave = connector driver / key register side.
interface ps2_keyboard_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] key_data;
   logic       key_valid;
   logic       key_release;
   logic       rx_error;
   logic       busy;

   modport master (
      input  ps2_clk,
      input  ps2_data,
      output key_data,
      output key_valid,
      output key_release,
      output rx_error,
      output busy
   );

   modport slave (
      output ps2_clk,
      output ps2_data,
      input  key_data,
      input  key_valid,
      input  key_release,
      input  rx_error,
      input  busy
   );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit deframer, make/break (0xF0) decode.
// Optional macro PS2_PARITY_CHECK_EN: when defined, odd-parity failures are reported and dropped.
module ps2_keyboard_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              reset,
   ps2_keyboard_rx_if.master kb
);

   localparam int FCNT_W = $clog2(FILTER_LEN + 1);
   localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic              ps2_clk_p0, ps2_clk_p1;
   logic              ps2_data_p0, ps2_data_p1;
   logic              clk_filt;
   logic [FCNT_W-1:0] filt_cnt;
   logic              flip;
   logic              fall;

   state_t            state;
   logic [7:0]        shift_reg;
   logic [2:0]        bit_cnt;
   logic              break_pending;
   logic [TMR_W-1:0]  timer;
   logic              frame_good;
   logic              timeout;

   logic [7:0]        key_data_r;
   logic              key_valid_r;
   logic              key_release_r;
   logic              rx_error_r;
   logic              busy_r;

   // Stage p0/p1: two-flop synchronisers, idle level is high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps2_clk_p0  <= 1'b1;
         ps2_clk_p1  <= 1'b1;
         ps2_data_p0 <= 1'b1;
         ps2_data_p1 <= 1'b1;
      end else begin
         ps2_clk_p0  <= kb.ps2_clk;
         ps2_clk_p1  <= ps2_clk_p0;
         ps2_data_p0 <= kb.ps2_data;
         ps2_data_p1 <= ps2_data_p0;
      end
   end

   // Filter: level flips only after FILTER_LEN consecutive disagreeing samples
   assign flip = (ps2_clk_p1 != clk_filt) && (filt_cnt == FCNT_W'(FILTER_LEN - 1));
   assign fall = flip && clk_filt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else if (ps2_clk_p1 == clk_filt) begin
         filt_cnt <= '0;
      end else if (flip) begin
         clk_filt <= ~clk_filt;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   logic parity_bit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         parity_bit <= 1'b0;
      else if (state == PARITY && fall)
         parity_bit <= ps2_data_p1;
   end

   // Sampled in STOP, so ps2_data_p1 is the stop bit here
   assign frame_good = ps2_data_p1 && (^{shift_reg, parity_bit});
`else
   assign frame_good = ps2_data_p1;
`endif

   // A fall in the same cycle always wins over the timeout
   assign timeout = (state != IDLE) && !fall && (timer == TMR_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         shift_reg     <= '0;
         bit_cnt       <= '0;
         break_pending <= 1'b0;
         timer         <= '0;
         key_data_r    <= '0;
         key_valid_r   <= 1'b0;
         key_release_r <= 1'b0;
         rx_error_r    <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         key_valid_r   <= 1'b0;
         key_release_r <= 1'b0;
         rx_error_r    <= 1'b0;

         if (state == IDLE || fall)
            timer <= '0;
         else
            timer <= timer + 1'b1;

         case (state)
            IDLE: begin
               if (fall && !ps2_data_p1) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  busy_r  <= 1'b1;
               end
            end
            DATA: begin
               if (fall) begin
                  shift_reg <= {ps2_data_p1, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= PARITY;
               end
            end
            PARITY: begin
               if (fall)
                  state <= STOP;
            end
            STOP: begin
               if (fall) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
                  if (!frame_good) begin
                     rx_error_r <= 1'b1;
                  end else if (shift_reg == 8'hF0) begin
                     break_pending <= 1'b1;
                  end else if (shift_reg != 8'hE0) begin
                     if (break_pending) begin
                        key_release_r <= 1'b1;
                        break_pending <= 1'b0;
                        if (shift_reg == key_data_r)
                           key_data_r <= 8'h00;
                     end else begin
                        key_data_r  <= shift_reg;
                        key_valid_r <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (timeout) begin
            state      <= IDLE;
            busy_r     <= 1'b0;
            rx_error_r <= 1'b1;
            timer      <= '0;
            bit_cnt    <= '0;
         end
      end
   end

   assign kb.key_data    = key_data_r;
   assign kb.key_valid   = key_valid_r;
   assign kb.key_release = key_release_r;
   assign kb.rx_error    = rx_error_r;
   assign kb.busy        = busy_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frames driven bit by bit, strobes counted by a negedge monitor.
module tb_ps2_keyboard_rx;

   localparam int FILTER_LEN     = 8;
   localparam int TIMEOUT_CYCLES = 1000;
   localparam int HALF           = 40;

   logic clk;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   int   cyc = 0;
   int   cnt_valid = 0, cnt_rel = 0, cnt_err = 0, cnt_busy = 0, cnt_wide = 0;
   logic prev_valid = 1'b0, prev_rel = 1'b0, prev_err = 1'b0;
   int   s_valid, s_rel, s_err, s_busy;
   int   t_last_drop;
   int   t_err;
   logic [7:0] exp_kd;

   ps2_keyboard_rx_if kb ();

   ps2_keyboard_rx #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .kb   (kb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      cnt_valid <= cnt_valid + int'(kb.key_valid);
      cnt_rel   <= cnt_rel + int'(kb.key_release);
      cnt_err   <= cnt_err + int'(kb.rx_error);
      cnt_busy  <= cnt_busy + int'(kb.busy);
      cnt_wide  <= cnt_wide + int'((kb.key_valid && prev_valid) || (kb.key_release && prev_rel) ||
                                   (kb.rx_error && prev_err));
      prev_valid <= kb.key_valid;
      prev_rel   <= kb.key_release;
      prev_err   <= kb.rx_error;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      @(negedge clk);
      s_valid = cnt_valid;
      s_rel   = cnt_rel;
      s_err   = cnt_err;
      s_busy  = cnt_busy;
   endtask

   task automatic send_bit(input logic b);
      kb.ps2_data = b;
      repeat (HALF) @(negedge clk);
      kb.ps2_clk  = 1'b0;
      t_last_drop = cyc;
      repeat (HALF) @(negedge clk);
      kb.ps2_clk  = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ par_flip);
      send_bit(stop);
      kb.ps2_data = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic check_deltas(input string tag, input int dv, input int dr, input int de);
      @(negedge clk);
      check_eq({tag, "_valid"},   32'(cnt_valid - s_valid), 32'(dv));
      check_eq({tag, "_release"}, 32'(cnt_rel - s_rel),     32'(dr));
      check_eq({tag, "_error"},   32'(cnt_err - s_err),     32'(de));
   endtask

   initial begin
      reset       = 1'b0;
      kb.ps2_clk  = 1'b1;
      kb.ps2_data = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("rst_key_data", 32'(kb.key_data), 32'h00);
      check_eq("rst_strobes",  32'({kb.key_valid, kb.key_release, kb.rx_error}), 32'h0);
      check_eq("rst_busy",     32'(kb.busy), 32'h0);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      // Plain make code
      snap();
      send_frame(8'h1C, 1'b0, 1'b1);
      check_eq("make1c_key_data", 32'(kb.key_data), 32'h1C);
      check_deltas("make1c", 1, 0, 0);
      check_eq("make1c_busy_seen", 32'(cnt_busy - s_busy > 0), 32'h1);
      check_eq("make1c_busy_end", 32'(kb.busy), 32'h0);

      // Break prefix then matching code
      snap();
      send_frame(8'hF0, 1'b0, 1'b1);
      check_deltas("f0", 0, 0, 0);
      check_eq("f0_key_data", 32'(kb.key_data), 32'h1C);
      snap();
      send_frame(8'h1C, 1'b0, 1'b1);
      check_deltas("brk1c", 0, 1, 0);
      check_eq("brk1c_key_data", 32'(kb.key_data), 32'h00);

      // Break of a key that is not held
      snap();
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h32, 1'b0, 1'b1);
      check_deltas("brk32", 0, 1, 0);
      check_eq("brk32_key_data", 32'(kb.key_data), 32'h00);

      // Extended prefix is silent
      snap();
      send_frame(8'hE0, 1'b0, 1'b1);
      check_deltas("e0", 0, 0, 0);
      check_eq("e0_key_data", 32'(kb.key_data), 32'h00);

      // Wrong parity bit
      snap();
      send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      check_deltas("badpar", 0, 0, 1);
      exp_kd = 8'h00;
`else
      check_deltas("badpar", 1, 0, 0);
      exp_kd = 8'h1C;
`endif
      check_eq("badpar_key_data", 32'(kb.key_data), 32'(exp_kd));

      // Stop bit 0, then recovery
      snap();
      send_frame(8'h32, 1'b0, 1'b0);
      check_deltas("badstop", 0, 0, 1);
      check_eq("badstop_key_data", 32'(kb.key_data), 32'(exp_kd));
      snap();
      send_frame(8'h32, 1'b0, 1'b1);
      check_deltas("after_badstop", 1, 0, 0);
      check_eq("after_badstop_key_data", 32'(kb.key_data), 32'h32);

      // Stalled frame: start + 4 data bits, lines then held high
      snap();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      t_err = -1;
      for (int i = 0; i < 3 * TIMEOUT_CYCLES; i++) begin
         @(negedge clk);
         if (kb.rx_error) begin
            t_err = cyc;
            break;
         end
      end
      check_eq("timeout_seen", 32'(t_err >= 0), 32'h1);
      check_eq("timeout_latency_window",
               32'((t_err - t_last_drop >= TIMEOUT_CYCLES + FILTER_LEN) &&
                   (t_err - t_last_drop <= TIMEOUT_CYCLES + FILTER_LEN + 4)), 32'h1);
      @(negedge clk);
      check_eq("timeout_busy", 32'(kb.busy), 32'h0);
      check_deltas("timeout", 0, 0, 1);
      snap();
      send_frame(8'h32, 1'b0, 1'b1);
      check_deltas("after_timeout", 1, 0, 0);
      check_eq("after_timeout_key_data", 32'(kb.key_data), 32'h32);

      // Short glitch on ps2_clk while idle
      snap();
      kb.ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      kb.ps2_clk = 1'b1;
      repeat (4 * FILTER_LEN) @(negedge clk);
      check_eq("glitch_busy_cycles", 32'(cnt_busy - s_busy), 32'h0);
      check_deltas("glitch", 0, 0, 0);

      // Reset in the middle of a frame
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      check_eq("midframe_busy_before", 32'(kb.busy), 32'h1);
      reset = 1'b0;
      #1;
      check_eq("midrst_key_data", 32'(kb.key_data), 32'h00);
      check_eq("midrst_outputs",
               32'({kb.key_valid, kb.key_release, kb.rx_error, kb.busy}), 32'h0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      snap();
      send_frame(8'h1C, 1'b0, 1'b1);
      check_deltas("after_rst", 1, 0, 0);
      check_eq("after_rst_key_data", 32'(kb.key_data), 32'h1C);

      check_eq("strobe_width", 32'(cnt_wide), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
